load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, max consecutive REQ cycles without mem_ready before fault (legal 2..255).
REQ-002 SHALL have one clock and one synchronous, active-high reset; both listed first below.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 start  in  1  core requests an access; accepted only when busy=0.
REQ-006 is_store  in  1  1=store, 0=load; sampled at accept.
REQ-007 funct3  in  3  RV32I width code: 000 b, 001 h, 010 w, 100 bu, 101 hu; sampled at accept.
REQ-008 address  in  32  byte address from the ALU result; sampled at accept.
REQ-009 store_data  in  32  rs2 value; sampled at accept.
REQ-010 busy  out  1  access in flight; core stalls PC and register write.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 fault  out  1  one-cycle pulse coincident with done on misalign, illegal funct3 or timeout.
REQ-013 load_data  out  32  extended load result; valid with done, held until next load done.
REQ-014 mem_req  out  1  memory request valid.
REQ-015 mem_we  out  1  1=write.
REQ-016 mem_addr  out  32  word-aligned address, {address[31:2],2'b00}.
REQ-017 mem_wdata  out  32  lane-replicated store data.
REQ-018 mem_be  out  4  byte enables.
REQ-019 mem_ready  in  1  memory accepts/completes the request this cycle.
REQ-020 mem_rdata  in  32  read word, valid when mem_ready=1 and mem_we=0.

Function
REQ-021 States SHALL be IDLE, REQ, DONE, FAULT; busy=1 in every state except IDLE.
REQ-022 IDLE: start=1 SHALL latch all request inputs; next state FAULT if illegal/misaligned, else REQ.
REQ-023 Illegal: funct3 in {011,110,111}, or store with funct3 in {100,101}; misaligned: half with address[0]=1, word with address[1:0]!=0.
REQ-024 REQ: mem_req=1 with mem_we/mem_addr/mem_wdata/mem_be stable every cycle until mem_ready=1; mem_ready=1 SHALL move to DONE, load capturing mem_rdata.
REQ-025 REQ: a wait counter SHALL count cycles with mem_ready=0; reaching TIMEOUT_CYCLES SHALL move to FAULT, mem_req drops next cycle.
REQ-026 DONE: done=1 one cycle, then IDLE; FAULT: done=1 and fault=1 one cycle, no memory request ever issued, then IDLE.
REQ-027 Minimum latency: start accepted at edge N, mem_ready=1 in cycle N+1 -> done in cycle N+2; next start accepted the cycle busy is 0.
REQ-028 start while busy=1 SHALL be ignored, never queued.
REQ-029 mem_be: byte 4'b0001<<address[1:0]; half 4'b0011<<{address[1],1'b0}; word 4'b1111; same for loads.
REQ-030 mem_wdata: byte {4{store_data[7:0]}}, half {2{store_data[15:0]}}, word store_data.
REQ-031 Load: lane = mem_rdata>>(8*address[1:0]); b/h sign-extend bit 7/15; bu/hu zero-extend; w unchanged.
REQ-032 Stores and faults SHALL leave load_data unchanged.
REQ-033 Outside REQ, mem_req=0 and mem_we=0.

Reset
REQ-034 reset=1 at an edge SHALL force IDLE, counter=0, busy=done=fault=mem_req=mem_we=0, load_data=0, mem_be=0, mem_addr=0, mem_wdata=0, from any state including mid-REQ.
REQ-035 reset SHALL dominate start in the same cycle; no request accepted.

Verification
REQ-036 Load lb, address=0x0000_0007, mem_rdata=0x80FF_1234, mem_ready in first REQ cycle -> mem_be=1000, done at N+2, load_data=0xFFFF_FF80.
REQ-037 Store sh, address=0x12, store_data=0xDEAD_BEEF, mem_ready after 3 wait cycles -> mem_addr=0x10, mem_be=1100, mem_wdata=0xBEEF_BEEF held stable 4 cycles, done, load_data unchanged.
REQ-038 Load lw, address=0x6 -> mem_req never asserted, done=fault=1 at N+1, busy=0 at N+2.
REQ-039 Load lhu, mem_ready stuck 0 -> fault after 16 REQ cycles; repeat with mem_ready at cycle 16 of REQ -> normal done, no fault; start pulses during busy ignored.
REQ-040 reset asserted in 2nd REQ cycle -> next cycle all outputs 0, IDLE; fresh lbu address=0x1, mem_rdata=0x0000_9A00 -> load_data=0x0000_009A.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: turns one core access into a single word-aligned memory request.
// Latency: done two cycles after accept when memory is ready at once; faults on bad requests complete one cycle after accept.
// Backpressure: busy stalls the core; mem_ready stretches REQ until the wait counter expires.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] load_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } state_t;

  // Wait-counter value seen in the last REQ cycle that may still complete.
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      state_next;
  logic [7:0]  wait_cnt;
  logic        store_q;
  logic [2:0]  funct3_q;
  logic [1:0]  offset_q;

  logic        bad_req;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [31:0] lane;
  logic [31:0] load_ext;

  // Classify the incoming request and precompute its byte lanes.
  always_comb begin
    bad_req    = 1'b0;
    be_calc    = 4'b0000;
    wdata_calc = store_data;
    case (funct3)
      3'b000, 3'b100: begin
        be_calc    = 4'b0001 << address[1:0];
        wdata_calc = {4{store_data[7:0]}};
        bad_req    = is_store && funct3[2];
      end
      3'b001, 3'b101: begin
        be_calc    = 4'b0011 << {address[1], 1'b0};
        wdata_calc = {2{store_data[15:0]}};
        bad_req    = address[0] || (is_store && funct3[2]);
      end
      3'b010: begin
        be_calc    = 4'b1111;
        wdata_calc = store_data;
        bad_req    = (address[1:0] != 2'b00);
      end
      default: bad_req = 1'b1;
    endcase
  end

  // Shift the addressed lane down and extend it according to the latched width code.
  always_comb begin
    lane     = mem_rdata >> {offset_q, 3'b000};
    load_ext = lane;
    case (funct3_q)
      3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_ext = {24'd0, lane[7:0]};
      3'b101:  load_ext = {16'd0, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  // Next-state logic; memory completion takes priority over the timeout in the same cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = bad_req ? FAULT : REQ;
      end
      REQ: begin
        if (mem_ready)                  state_next = DONE;
        else if (wait_cnt == LAST_WAIT) state_next = FAULT;
      end
      DONE:    state_next = IDLE;
      FAULT:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status and request strobes decode directly from the state.
  always_comb begin
    busy    = (state != IDLE);
    done    = (state == DONE) || (state == FAULT);
    fault   = (state == FAULT);
    mem_req = (state == REQ);
    mem_we  = (state == REQ) && store_q;
  end

  // State, wait counter, latched request and load result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= 8'd0;
      store_q   <= 1'b0;
      funct3_q  <= 3'b000;
      offset_q  <= 2'b00;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_be    <= 4'b0000;
      load_data <= 32'd0;
    end else begin
      state <= state_next;
      if (state == IDLE && start) begin
        store_q   <= is_store;
        funct3_q  <= funct3;
        offset_q  <= address[1:0];
        mem_addr  <= {address[31:2], 2'b00};
        mem_wdata <= wdata_calc;
        mem_be    <= be_calc;
        wait_cnt  <= 8'd0;
      end
      if (state == REQ) begin
        if (mem_ready) begin
          wait_cnt <= 8'd0;
          if (!store_q) load_data <= load_ext;
        end else begin
          wait_cnt <= wait_cnt + 8'd1;
        end
      end else begin
        wait_cnt <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: table of accesses driven one at a time with a done/fault/load_data scoreboard.
// Latency: checks request cycle count, done timing and busy release for each access.
// Backpressure: memory readiness delayed per vector; start pulses while busy must be ignored.
module tb_load_store_unit;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] address;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic        fault;
  logic [31:0] load_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          waitc;     // wait cycles before mem_ready; -1 = never ready
    bit          pb;        // pulse start while busy
    logic        exp_fault;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_ld;
  } vec_t;

  typedef struct {
    logic        fault;
    logic [31:0] ld;
  } sb_t;

  sb_t  sb_q[$];
  vec_t vecs[15];

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store), .funct3(funct3),
    .address(address), .store_data(store_data), .busy(busy), .done(done), .fault(fault),
    .load_data(load_data), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard: every completion must match the oldest expected result.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        chk("sb_fault", {31'd0, fault}, {31'd0, e.fault});
        chk("sb_load_data", load_data, e.ld);
      end
    end
  end

  task automatic do_access(input vec_t v);
    int n;
    int req;
    int exp_req;
    sb_t e;
    n = 0;
    while (busy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_before_start", {31'd0, busy}, 32'd0);
    start      = 1'b1;
    is_store   = v.st;
    funct3     = v.f3;
    address    = v.addr;
    store_data = v.sdata;
    e.fault = v.exp_fault;
    e.ld    = v.exp_ld;
    sb_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    req = 0;
    while (mem_req && req < 40) begin
      chk("mem_addr", mem_addr, v.addr & 32'hFFFF_FFFC);
      chk("mem_be", {28'd0, mem_be}, {28'd0, v.exp_be});
      chk("mem_we", {31'd0, mem_we}, {31'd0, v.st});
      if (v.st) chk("mem_wdata", mem_wdata, v.exp_wdata);
      mem_ready = (v.waitc == req);
      mem_rdata = (v.waitc == req) ? v.rdata : ~v.rdata;
      if (v.pb) begin
        start    = 1'b1;
        is_store = ~v.st;
        funct3   = 3'b010;
        address  = 32'hFFFF_FFF0;
      end
      @(posedge clk); #1;
      mem_ready = 1'b0;
      req++;
    end
    if (v.exp_fault) exp_req = (v.waitc < 0) ? TO : 0;
    else             exp_req = v.waitc + 1;
    chk("req_cycles", req, exp_req);
    chk("done_timing", {31'd0, done}, 32'd1);
    chk("fault_timing", {31'd0, fault}, {31'd0, v.exp_fault});
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_released", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    chk("no_queued_start", {30'd0, mem_req, busy}, 32'd0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
    chk({nm, "_done"}, {30'd0, done, fault}, 32'd0);
    chk({nm, "_req"}, {30'd0, mem_req, mem_we}, 32'd0);
    chk({nm, "_be"}, {28'd0, mem_be}, 32'd0);
    chk({nm, "_addr"}, mem_addr, 32'd0);
    chk({nm, "_wdata"}, mem_wdata, 32'd0);
    chk({nm, "_load_data"}, load_data, 32'd0);
  endtask

  initial begin
    vec_t v;
    //            st    f3      addr         sdata         rdata        wait pb fault be       wdata         exp_ld
    vecs[0]  = '{1'b0, 3'b000, 32'h0000_0007, 32'h0,        32'h80FF_1234, 0,  0, 1'b0, 4'b1000, 32'h0,        32'hFFFF_FF80};
    vecs[1]  = '{1'b1, 3'b001, 32'h0000_0012, 32'hDEAD_BEEF, 32'h0,        3,  1, 1'b0, 4'b1100, 32'hBEEF_BEEF, 32'hFFFF_FF80};
    vecs[2]  = '{1'b0, 3'b010, 32'h0000_0006, 32'h0,        32'h0,         0,  0, 1'b1, 4'b0000, 32'h0,        32'hFFFF_FF80};
    vecs[3]  = '{1'b0, 3'b101, 32'h0000_0102, 32'h0,        32'h5555_5555, -1, 0, 1'b1, 4'b1100, 32'h0,        32'hFFFF_FF80};
    vecs[4]  = '{1'b0, 3'b101, 32'h0000_0102, 32'h0,        32'hABCD_0000, 15, 1, 1'b0, 4'b1100, 32'h0,        32'h0000_ABCD};
    vecs[5]  = '{1'b0, 3'b001, 32'h0000_0020, 32'h0,        32'h1234_8001, 1,  0, 1'b0, 4'b0011, 32'h0,        32'hFFFF_8001};
    vecs[6]  = '{1'b0, 3'b100, 32'h0000_0001, 32'h0,        32'h0000_9A00, 0,  0, 1'b0, 4'b0010, 32'h0,        32'h0000_009A};
    vecs[7]  = '{1'b1, 3'b000, 32'h0000_0003, 32'h1122_3344, 32'h0,        0,  0, 1'b0, 4'b1000, 32'h4444_4444, 32'h0000_009A};
    vecs[8]  = '{1'b1, 3'b010, 32'h0000_0008, 32'hCAFE_F00D, 32'h0,        2,  0, 1'b0, 4'b1111, 32'hCAFE_F00D, 32'h0000_009A};
    vecs[9]  = '{1'b1, 3'b100, 32'h0000_0000, 32'h0000_00AA, 32'h0,        0,  0, 1'b1, 4'b0000, 32'h0,        32'h0000_009A};
    vecs[10] = '{1'b0, 3'b011, 32'h0000_0000, 32'h0,        32'h0,         0,  0, 1'b1, 4'b0000, 32'h0,        32'h0000_009A};
    vecs[11] = '{1'b0, 3'b010, 32'h0000_000C, 32'h0,        32'h8765_4321, 0,  0, 1'b0, 4'b1111, 32'h0,        32'h8765_4321};
    vecs[12] = '{1'b0, 3'b000, 32'h0000_0001, 32'h0,        32'h0000_7F00, 0,  0, 1'b0, 4'b0010, 32'h0,        32'h0000_007F};
    vecs[13] = '{1'b1, 3'b001, 32'h0000_0001, 32'h0000_1234, 32'h0,        0,  0, 1'b1, 4'b0000, 32'h0,        32'h0000_007F};
    vecs[14] = '{1'b0, 3'b000, 32'h0000_0000, 32'h0,        32'h0000_00FE, 0,  0, 1'b0, 4'b0001, 32'h0,        32'hFFFF_FFFE};

    reset = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'b000;
    address = 32'd0; store_data = 32'd0; mem_ready = 1'b0; mem_rdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) do_access(vecs[i]);

    // Reset during the second REQ cycle, with start held high alongside it.
    start = 1'b1; is_store = 1'b0; funct3 = 3'b000; address = 32'h0000_0004;
    @(posedge clk); #1;
    start = 1'b0;
    chk("abort_in_req", {31'd0, mem_req}, 32'd1);
    @(posedge clk); #1;
    chk("abort_in_req2", {31'd0, mem_req}, 32'd1);
    reset = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    chk_all_zero("mid_req_reset");
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    chk("reset_beats_start", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    chk("reset_beats_start2", {30'd0, busy, mem_req}, 32'd0);

    v = '{1'b0, 3'b100, 32'h0000_0001, 32'h0, 32'h0000_9A00, 0, 0, 1'b0, 4'b0010, 32'h0, 32'h0000_009A};
    do_access(v);

    repeat (2) @(posedge clk);
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
